program_encoder_loader: RTL and testbench

//  Host-side counterpart of the 6-bit instruction decoder. Takes symbolic commands (op + arg) over a

---
 rtl/program_encoder_loader.sv | 171 +++++++++++++++++
 tb/tb_program_encoder_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder_loader.sv
// Host-side program loader: encodes symbolic commands into 6-bit ASIP words and
// writes them sequentially into program memory, always terminating with PAUSE.
module program_encoder_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [2:0]        cmd_arg,
  input  logic              cmd_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [5:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   prog_len
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | accepting one command
  // WRITE | writing the registered command word
  // TERM  | appending the terminating PAUSE
  // DONE  | program complete (sticky)
  // ERROR | load failed, err_code held (sticky)
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_TERM, S_DONE, S_ERROR
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL      = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

  localparam logic [3:0] OP_ADDI   = 4'd0;
  localparam logic [3:0] OP_SUBI   = 4'd1;
  localparam logic [3:0] OP_SR0    = 4'd2;
  localparam logic [3:0] OP_SRH0   = 4'd3;
  localparam logic [3:0] OP_CLR    = 4'd4;
  localparam logic [3:0] OP_MOV    = 4'd5;
  localparam logic [3:0] OP_BR     = 4'd6;
  localparam logic [3:0] OP_BRZ    = 4'd7;
  localparam logic [3:0] OP_MOVA   = 4'd8;
  localparam logic [3:0] OP_MOVR   = 4'd9;
  localparam logic [3:0] OP_MOVRHS = 4'd10;
  localparam logic [3:0] OP_PAUSE  = 4'd11;

  localparam logic [5:0] PAUSE_WORD = 6'b111111;

  state_t          state, state_nxt;
  logic [ADDR_W:0] cnt;
  logic [5:0]      word_q;
  logic            last_q;
  logic            pause_q;
  logic [1:0]      code_q;
  logic [5:0]      enc_word;
  logic [1:0]      chk_code;
  logic            restart;
  logic            accept;

  // Encoding and range check of the command currently on the bus.
  always_comb begin
    enc_word = 6'b000000;
    chk_code = 2'b00;
    case (cmd_op)
      OP_ADDI:   enc_word = {3'b000, cmd_arg};
      OP_SUBI:   enc_word = {3'b001, cmd_arg};
      OP_BR:     enc_word = {3'b100, cmd_arg};
      OP_BRZ:    enc_word = {3'b101, cmd_arg};
      OP_SR0:    begin enc_word = {4'b0100, cmd_arg[1:0]}; if (cmd_arg[2]) chk_code = 2'b10; end
      OP_SRH0:   begin enc_word = {4'b0101, cmd_arg[1:0]}; if (cmd_arg[2]) chk_code = 2'b10; end
      OP_MOV:    begin enc_word = {4'b0111, cmd_arg[1:0]}; if (cmd_arg[2]) chk_code = 2'b10; end
      OP_CLR:    begin enc_word = 6'b011000; if (cmd_arg != 3'd0) chk_code = 2'b10; end
      OP_MOVA:   begin enc_word = 6'b110000; if (cmd_arg != 3'd0) chk_code = 2'b10; end
      OP_MOVR:   begin enc_word = 6'b110001; if (cmd_arg != 3'd0) chk_code = 2'b10; end
      OP_MOVRHS: begin enc_word = 6'b110010; if (cmd_arg != 3'd0) chk_code = 2'b10; end
      OP_PAUSE:  begin enc_word = PAUSE_WORD; if (cmd_arg != 3'd0) chk_code = 2'b10; end
      default:   chk_code = 2'b01;
    endcase
    // The last slot is reserved for PAUSE unless the command itself is the final PAUSE.
    if (chk_code == 2'b00) begin
      if (cmd_last && (cmd_op == OP_PAUSE)) begin
        if (cnt == FULL) chk_code = 2'b11;
      end else if (cnt >= LAST_SLOT) begin
        chk_code = 2'b11;
      end
    end
  end

  assign restart = start && !abort &&
                   ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign accept  = (state == S_LOAD) && cmd_valid && !abort;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 6'b000000;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_DONE:  begin done = 1'b1; if (start) state_nxt = S_LOAD; end
      S_ERROR: begin err  = 1'b1; if (start) state_nxt = S_LOAD; end
      S_LOAD: begin
        cmd_ready = 1'b1;
        busy      = 1'b1;
        if (cmd_valid) state_nxt = (chk_code == 2'b00) ? S_WRITE : S_ERROR;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = word_q;
        if (!last_q)      state_nxt = S_LOAD;
        else if (pause_q) state_nxt = S_DONE;
        else              state_nxt = S_TERM;
      end
      S_TERM: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = PAUSE_WORD;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      word_q  <= 6'b000000;
      last_q  <= 1'b0;
      pause_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (restart) begin
        cnt <= '0;
      end else if (mem_we) begin
        cnt <= cnt + CNT_ONE;
      end
      if (abort || restart) begin
        code_q <= 2'b00;
      end else if (accept && (chk_code != 2'b00)) begin
        code_q <= chk_code;
      end
      if (accept && (chk_code == 2'b00)) begin
        word_q  <= enc_word;
        last_q  <= cmd_last;
        pause_q <= (cmd_op == OP_PAUSE);
      end
    end
  end

  assign mem_addr = cnt[ADDR_W-1:0];
  assign prog_len = cnt;
  assign err_code = code_q;

endmodule

// File: tb/tb_program_encoder_loader.sv
// Randomized and directed bench for program_encoder_loader, checked against a
// command-level reference model of the encoder/loader.
module tb_program_encoder_loader;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, cmd_valid, cmd_last;
  logic [3:0] cmd_op;
  logic [2:0] cmd_arg;
  logic       cmd_ready, mem_we, busy, done, err;
  logic [4:0] mem_addr;
  logic [5:0] mem_wdata;
  logic [1:0] err_code;
  logic [5:0] prog_len;

  logic       b_start, b_cmd_valid, b_cmd_last;
  logic [3:0] b_cmd_op;
  logic [2:0] b_cmd_arg;
  logic       b_cmd_ready, b_mem_we, b_busy, b_done, b_err;
  logic [1:0] b_mem_addr;
  logic [5:0] b_mem_wdata;
  logic [1:0] b_err_code;
  logic [2:0] b_prog_len;

  always #5 clk = ~clk;

  program_encoder_loader #(.ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_last(cmd_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .prog_len(prog_len)
  );

  program_encoder_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(b_start), .abort(1'b0),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op), .cmd_arg(b_cmd_arg),
    .cmd_last(b_cmd_last), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code), .prog_len(b_prog_len)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Memory writes seen on each DUT, packed as addr*64 + word.
  int got_q[$];
  int b_got_q[$];
  always @(posedge clk) begin
    if (mem_we)   got_q.push_back(int'(mem_addr) * 64 + int'(mem_wdata));
    if (b_mem_we) b_got_q.push_back(int'(b_mem_addr) * 64 + int'(b_mem_wdata));
  end

  // Program under test and model results.
  int p_op[64], p_arg[64];
  bit p_last[64];
  int p_n;
  int exp_q[$];
  bit exp_wr[64];
  int exp_word[64];
  int exp_err, exp_len, exp_stop;

  function automatic int legal_code(input int op, input int arg);
    if (op > 11) return 1;
    if ((op == 2 || op == 3 || op == 5) && arg > 3) return 2;
    if ((op == 4 || op >= 8) && arg != 0) return 2;
    return 0;
  endfunction

  function automatic int enc(input int op, input int arg);
    case (op)
      0: return arg;
      1: return 8 + arg;
      6: return 32 + arg;
      7: return 40 + arg;
      2: return 16 + arg;
      3: return 20 + arg;
      5: return 28 + arg;
      4: return 24;
      8: return 48;
      9: return 49;
      10: return 50;
      default: return 63;
    endcase
  endfunction

  task automatic model(input int depth);
    int cnt = 0;
    int code;
    bit room;
    exp_q.delete();
    exp_err  = 0;
    exp_stop = p_n - 1;
    for (int i = 0; i < p_n; i++) begin
      code = legal_code(p_op[i], p_arg[i]);
      if (code == 0) begin
        room = (p_last[i] && p_op[i] == 11) ? (cnt < depth) : (cnt < depth - 1);
        if (!room) code = 3;
      end
      if (code != 0) begin
        exp_err  = code;
        exp_wr[i] = 1'b0;
        exp_stop = i;
        break;
      end
      exp_wr[i]   = 1'b1;
      exp_word[i] = enc(p_op[i], p_arg[i]);
      exp_q.push_back(cnt * 64 + exp_word[i]);
      cnt++;
      if (p_last[i]) begin
        if (p_op[i] != 11) begin
          exp_q.push_back(cnt * 64 + 63);
          cnt++;
        end
        exp_stop = i;
        break;
      end
    end
    exp_len = cnt;
  endtask

  task automatic set_cmd(input int i, input int op, input int arg, input bit last);
    p_op[i] = op; p_arg[i] = arg; p_last[i] = last;
  endtask

  task automatic run_prog(input string name);
    int waited;
    model(32);
    got_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, "_busy_load"}, busy, 1);
    for (int i = 0; i <= exp_stop; i++) begin
      repeat ($urandom_range(0, 2)) begin
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_arg   = 3'($urandom);
        start     = ($urandom_range(0, 4) == 0);
        @(negedge clk);
        start = 1'b0;
      end
      cmd_valid = 1'b1;
      cmd_op    = 4'(p_op[i]);
      cmd_arg   = 3'(p_arg[i]);
      cmd_last  = p_last[i];
      waited = 0;
      while (!cmd_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) begin
        check({name, "_handshake_timeout"}, waited, 0);
        break;
      end
      @(negedge clk);
      check({name, "_we_after_hs"}, mem_we, exp_wr[i]);
      if (exp_wr[i]) check({name, "_wdata"}, mem_wdata, exp_word[i]);
    end
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    repeat (4) @(negedge clk);
    check({name, "_done"}, done, (exp_err == 0) ? 1 : 0);
    check({name, "_err"}, err, (exp_err != 0) ? 1 : 0);
    check({name, "_err_code"}, err_code, exp_err);
    check({name, "_prog_len"}, prog_len, exp_len);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({name, "_word"}, got_q[i], exp_q[i]);
  endtask

  task automatic rand_cmd(input int i, input bit last);
    int r = $urandom_range(0, 19);
    int op = (r >= 18) ? $urandom_range(12, 15) : r % 12;
    int arg;
    if ($urandom_range(0, 4) == 0) arg = $urandom_range(0, 7);
    else if (op == 2 || op == 3 || op == 5) arg = $urandom_range(0, 3);
    else if (op == 4 || op >= 8) arg = 0;
    else arg = $urandom_range(0, 7);
    set_cmd(i, op, arg, last);
  endtask

  initial begin
    int waited;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    cmd_op = 4'd0; cmd_arg = 3'd0; cmd_last = 1'b0;
    b_start = 1'b0; b_cmd_valid = 1'b0; b_cmd_op = 4'd0; b_cmd_arg = 3'd0; b_cmd_last = 1'b0;
    #12;
    check("rst_ready", cmd_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_len", prog_len, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", cmd_ready, 0);

    // ADDI 5, BRZ 2, MOVR (last)
    p_n = 3;
    set_cmd(0, 0, 5, 0); set_cmd(1, 7, 2, 0); set_cmd(2, 9, 0, 1);
    run_prog("t1");
    if (got_q.size() == 4) begin
      check("t1_w0", got_q[0], 0 * 64 + 6'b000101);
      check("t1_w1", got_q[1], 1 * 64 + 6'b101010);
      check("t1_w2", got_q[2], 2 * 64 + 6'b110001);
      check("t1_w3", got_q[3], 3 * 64 + 6'b111111);
    end else check("t1_count", got_q.size(), 4);

    // SR0 1, PAUSE (last): no extra terminator
    p_n = 2;
    set_cmd(0, 2, 1, 0); set_cmd(1, 11, 0, 1);
    run_prog("t2");

    // SRH0 with arg 4, then an illegal op
    p_n = 1; set_cmd(0, 3, 4, 1); run_prog("t3a");
    p_n = 1; set_cmd(0, 13, 0, 0); run_prog("t3b");

    // Capacity boundaries at DEPTH=32
    p_n = 32;
    for (int i = 0; i < 31; i++) set_cmd(i, 0, i % 8, 0);
    set_cmd(31, 11, 0, 1);
    run_prog("full_pause");
    set_cmd(31, 4, 0, 1);
    run_prog("full_ovf");
    p_n = 31; set_cmd(30, 1, 3, 1);
    run_prog("full_term");

    // Abort during the WRITE cycle
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_arg = 3'd7; cmd_last = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    check("abort_pre_we", mem_we, 1);
    abort = 1'b1; start = 1'b1;
    #1 check("abort_we", mem_we, 0);
    @(negedge clk); abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_ready", cmd_ready, 0);

    // Abort clears a sticky error
    p_n = 1; set_cmd(0, 14, 0, 1); run_prog("pre_abort_err");
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("abort_err_clr", err, 0);
    check("abort_code_clr", err_code, 0);

    // Randomized programs
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        p_n = $urandom_range(29, 34);
        for (int i = 0; i < p_n; i++) set_cmd(i, $urandom_range(0, 1), $urandom_range(0, 7), i == p_n - 1);
        if ($urandom_range(0, 1) == 1) set_cmd(p_n - 1, 11, 0, 1);
      end else begin
        p_n = $urandom_range(1, 8);
        for (int i = 0; i < p_n; i++) rand_cmd(i, i == p_n - 1);
      end
      run_prog($sformatf("rnd%0d", t));
    end

    // Small instance (DEPTH=4): three ADDI then CLR last -> overflow
    b_got_q.delete();
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_cmd_valid = 1'b1;
      b_cmd_op    = (i < 3) ? 4'd0 : 4'd4;
      b_cmd_arg   = (i < 3) ? 3'(i + 1) : 3'd0;
      b_cmd_last  = (i == 3);
      waited = 0;
      while (!b_cmd_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) begin
        check("small_handshake_timeout", waited, 0);
        break;
      end
      @(negedge clk);
      check("small_we_after_hs", b_mem_we, (i < 3) ? 1 : 0);
    end
    b_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("small_err", b_err, 1);
    check("small_code", b_err_code, 3);
    check("small_len", b_prog_len, 3);
    check("small_nwords", b_got_q.size(), 3);
    if (b_got_q.size() == 3) check("small_w2", b_got_q[2], 2 * 64 + 3);

    // Asynchronous reset in the middle of a load
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_arg = 3'd1; cmd_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", cmd_ready, 0);
    check("arst_we", mem_we, 0);
    check("arst_len", prog_len, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_wdata", mem_wdata, 0);
    cmd_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("arst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
